// File: rtl/enemy_life_if.sv
// Signal bundle between one enemy's life manager and the game top level:
// frame strobe, enemy/bullet/player positions in, life state and event pulses out.
interface enemy_life_if;
  logic       frame_clk;
  logic [8:0] Obj_X_Pos;
  logic [8:0] Obj_Y_Pos;
  logic [8:0] Bullet_X;
  logic [8:0] Bullet_Y;
  logic       bullet_valid;
  logic [8:0] Player_X;
  logic [8:0] Player_Y;
  logic       is_alive;
  logic       is_hurt;
  logic [2:0] hp;
  logic       bullet_hit;
  logic       kill;
  logic       respawn;
  logic       player_hit;
  logic [7:0] kill_count;

  modport master (
    output frame_clk, Obj_X_Pos, Obj_Y_Pos, Bullet_X, Bullet_Y, bullet_valid,
           Player_X, Player_Y,
    input  is_alive, is_hurt, hp, bullet_hit, kill, respawn, player_hit, kill_count
  );

  modport slave (
    input  frame_clk, Obj_X_Pos, Obj_Y_Pos, Bullet_X, Bullet_Y, bullet_valid,
           Player_X, Player_Y,
    output is_alive, is_hurt, hp, bullet_hit, kill, respawn, player_hit, kill_count
  );
endinterface

// File: rtl/enemy_life.sv
// Per-enemy life/collision manager: resolves bullet hits and player contact once
// per frame tick, tracks HP, invulnerability and respawn, and emits event pulses.
module enemy_life #(
  parameter int id             = 0,
  parameter int MAX_HP         = 3,
  parameter int Width          = 26,
  parameter int Height         = 26,
  parameter int BULLET_SIZE    = 4,
  parameter int PLAYER_SIZE    = 26,
  parameter int INVULN_FRAMES  = 8,
  parameter int RESPAWN_FRAMES = 120,
  parameter int CONTACT_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  enemy_life_if.slave bus
);

  typedef enum logic [1:0] {ALIVE, HURT, DEAD} state_t;

  localparam logic [2:0] HP_INIT     = 3'(MAX_HP);
  localparam logic [7:0] INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [7:0] RESP_INIT   = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] CONT_INIT   = 8'(CONTACT_FRAMES);
  localparam logic [9:0] ENEMY_W     = 10'(Width);
  localparam logic [9:0] ENEMY_H     = 10'(Height);
  localparam logic [9:0] BULLET_E    = 10'(BULLET_SIZE);
  localparam logic [9:0] PLAYER_E    = 10'(PLAYER_SIZE);

  // The instance tag has no logic; it only names a block in the elaborated tree.
  if (id < 0) begin : g_negative_id
  end

  state_t     state_reg, state_next;
  logic [2:0] hp_reg, hp_next;
  logic [7:0] timer_reg, timer_next;
  logic [7:0] cool_reg, cool_next;
  logic [7:0] kills_reg, kills_next;
  logic       fdly_reg, tick_reg;
  logic       bullet_hit_reg, bullet_hit_next;
  logic       kill_reg, kill_next;
  logic       respawn_reg, respawn_next;
  logic       player_hit_reg, player_hit_next;
  logic       bov, pov;

  // Half-open box test done in 10 bits so boxes near X/Y=511 do not wrap.
  function automatic logic boxes_overlap(
    input logic [8:0] ax, input logic [8:0] ay, input logic [9:0] aw, input logic [9:0] ah,
    input logic [8:0] bx, input logic [8:0] by, input logic [9:0] bw, input logic [9:0] bh
  );
    boxes_overlap = ({1'b0, bx} < ({1'b0, ax} + aw)) && ({1'b0, ax} < ({1'b0, bx} + bw)) &&
                    ({1'b0, by} < ({1'b0, ay} + ah)) && ({1'b0, ay} < ({1'b0, by} + bh));
  endfunction

  assign bov = bus.bullet_valid &&
               boxes_overlap(bus.Obj_X_Pos, bus.Obj_Y_Pos, ENEMY_W, ENEMY_H,
                             bus.Bullet_X, bus.Bullet_Y, BULLET_E, BULLET_E);
  assign pov = boxes_overlap(bus.Obj_X_Pos, bus.Obj_Y_Pos, ENEMY_W, ENEMY_H,
                             bus.Player_X, bus.Player_Y, PLAYER_E, PLAYER_E);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= ALIVE;
      hp_reg         <= HP_INIT;
      timer_reg      <= 8'd0;
      cool_reg       <= 8'd0;
      kills_reg      <= 8'd0;
      fdly_reg       <= 1'b0;
      tick_reg       <= 1'b0;
      bullet_hit_reg <= 1'b0;
      kill_reg       <= 1'b0;
      respawn_reg    <= 1'b0;
      player_hit_reg <= 1'b0;
    end else begin
      fdly_reg       <= bus.frame_clk;
      tick_reg       <= bus.frame_clk & ~fdly_reg;
      state_reg      <= state_next;
      hp_reg         <= hp_next;
      timer_reg      <= timer_next;
      cool_reg       <= cool_next;
      kills_reg      <= kills_next;
      bullet_hit_reg <= bullet_hit_next;
      kill_reg       <= kill_next;
      respawn_reg    <= respawn_next;
      player_hit_reg <= player_hit_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hp_next         = hp_reg;
    timer_next      = timer_reg;
    cool_next       = cool_reg;
    kills_next      = kills_reg;
    bullet_hit_next = 1'b0;
    kill_next       = 1'b0;
    respawn_next    = 1'b0;
    player_hit_next = 1'b0;

    if (tick_reg) begin
      case (state_reg)
        ALIVE: begin
          if (bov) begin
            bullet_hit_next = 1'b1;
            if (hp_reg > 3'd1) begin
              hp_next    = hp_reg - 3'd1;
              timer_next = INVULN_INIT;
              state_next = HURT;
            end else begin
              hp_next    = 3'd0;
              kill_next  = 1'b1;
              timer_next = RESP_INIT;
              state_next = DEAD;
              if (kills_reg != 8'hFF) kills_next = kills_reg + 8'd1;
            end
          end
        end
        HURT: begin
          timer_next = timer_reg - 8'd1;
          if (timer_reg == 8'd1) state_next = ALIVE;
        end
        DEAD: begin
          timer_next = timer_reg - 8'd1;
          if (timer_reg == 8'd1) begin
            state_next   = ALIVE;
            hp_next      = HP_INIT;
            respawn_next = 1'b1;
          end
        end
        default: state_next = ALIVE;
      endcase

      // Contact uses the pre-tick state, so a lethal hit and contact can both pulse.
      if (state_reg != DEAD && pov && cool_reg == 8'd0) begin
        player_hit_next = 1'b1;
        cool_next       = CONT_INIT;
      end else if (cool_reg != 8'd0) begin
        cool_next = cool_reg - 8'd1;
      end
    end
  end

  assign bus.is_alive   = (state_reg != DEAD);
  assign bus.is_hurt    = (state_reg == HURT);
  assign bus.hp         = hp_reg;
  assign bus.bullet_hit = bullet_hit_reg;
  assign bus.kill       = kill_reg;
  assign bus.respawn    = respawn_reg;
  assign bus.player_hit = player_hit_reg;
  assign bus.kill_count = kills_reg;

endmodule

// File: tb/tb_enemy_life.sv
// Directed bench for enemy_life: reset, hits/invulnerability, edge cases,
// kill/respawn, player contact cooldown and asynchronous reset mid-HURT.
module tb_enemy_life;
  logic Clk = 1'b0;
  logic Reset_n;
  always #10 Clk = ~Clk;

  enemy_life_if bus();

  enemy_life #(.id(0)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));

  int   n_cmp = 0;
  int   n_bad = 0;
  int   stray = 0;
  logic p_bh, p_kill, p_resp, p_ph;

  task automatic set_defaults;
    bus.frame_clk    = 1'b0;
    bus.Obj_X_Pos    = 9'd50;
    bus.Obj_Y_Pos    = 9'd40;
    bus.Bullet_X     = 9'd300;
    bus.Bullet_Y     = 9'd300;
    bus.bullet_valid = 1'b0;
    bus.Player_X     = 9'd400;
    bus.Player_Y     = 9'd300;
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Reset_n = 1'b0;
    set_defaults();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    stray = 0;
  endtask

  // One frame strobe; captures the pulses of the consuming edge and counts any
  // pulse still high one Clk later as a stray.
  task automatic frame_tick;
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    p_bh = bus.bullet_hit; p_kill = bus.kill; p_resp = bus.respawn; p_ph = bus.player_hit;
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    @(posedge Clk);
    #1;
    if (bus.bullet_hit || bus.kill || bus.respawn || bus.player_hit) stray++;
  endtask

  task automatic test_reset;
    int cnt;
    @(negedge Clk);
    Reset_n = 1'b0;
    set_defaults();
    @(posedge Clk);
    #1;
    n_cmp++; if (bus.is_alive !== 1'b1) begin n_bad++; $display("FAIL rst_alive: got %b want 1", bus.is_alive); end
    n_cmp++; if (bus.hp !== 3'd3) begin n_bad++; $display("FAIL rst_hp: got %0d want 3", bus.hp); end
    n_cmp++; if (bus.is_hurt !== 1'b0) begin n_bad++; $display("FAIL rst_hurt: got %b want 0", bus.is_hurt); end
    n_cmp++; if ({bus.bullet_hit, bus.kill, bus.respawn, bus.player_hit} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_pulses: got %b want 0000", {bus.bullet_hit, bus.kill, bus.respawn, bus.player_hit}); end
    n_cmp++; if (bus.kill_count !== 8'd0) begin n_bad++; $display("FAIL rst_kills: got %0d want 0", bus.kill_count); end
    @(negedge Clk);
    Reset_n = 1'b1;
    stray = 0;
    cnt = 0;
    repeat (10) begin
      frame_tick();
      cnt += int'(p_bh) + int'(p_kill) + int'(p_resp) + int'(p_ph);
    end
    n_cmp++; if (cnt + stray !== 0) begin n_bad++; $display("FAIL idle_pulses: got %0d want 0", cnt + stray); end
    n_cmp++; if (bus.hp !== 3'd3 || bus.is_alive !== 1'b1) begin
      n_bad++; $display("FAIL idle_state: got hp=%0d alive=%b want hp=3 alive=1", bus.hp, bus.is_alive); end
    $display("test_reset: 10 idle ticks, hp=%0d alive=%b", bus.hp, bus.is_alive);
  endtask

  task automatic test_hit_invuln;
    int hits;
    do_reset();
    bus.Bullet_X = 9'd60; bus.Bullet_Y = 9'd50; bus.bullet_valid = 1'b1;
    frame_tick();
    n_cmp++; if (p_bh !== 1'b1 || p_kill !== 1'b0) begin n_bad++; $display("FAIL hit1_pulse: got bh=%b kill=%b want 1/0", p_bh, p_kill); end
    n_cmp++; if (bus.hp !== 3'd2 || bus.is_hurt !== 1'b1) begin
      n_bad++; $display("FAIL hit1_state: got hp=%0d hurt=%b want 2/1", bus.hp, bus.is_hurt); end
    hits = 0;
    for (int i = 1; i <= 8; i++) begin
      frame_tick();
      hits += int'(p_bh);
      if (i == 7) begin
        n_cmp++; if (bus.is_hurt !== 1'b1) begin n_bad++; $display("FAIL hurt_tick7: got %b want 1", bus.is_hurt); end
      end
    end
    n_cmp++; if (hits !== 0 || bus.hp !== 3'd2) begin n_bad++; $display("FAIL invuln: got hits=%0d hp=%0d want 0/2", hits, bus.hp); end
    n_cmp++; if (bus.is_hurt !== 1'b0) begin n_bad++; $display("FAIL hurt_end: got %b want 0", bus.is_hurt); end
    frame_tick();
    n_cmp++; if (p_bh !== 1'b1 || bus.hp !== 3'd1) begin n_bad++; $display("FAIL hit2: got bh=%b hp=%0d want 1/1", p_bh, bus.hp); end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL hit_pulse_width: got %0d stray want 0", stray); end
    $display("test_hit_invuln: hp=%0d hurt=%b", bus.hp, bus.is_hurt);
  endtask

  task automatic test_edge_touch;
    int hits;
    do_reset();
    hits = 0;
    bus.Bullet_X = 9'd76; bus.Bullet_Y = 9'd50; bus.bullet_valid = 1'b1;
    repeat (5) begin frame_tick(); hits += int'(p_bh); end
    bus.Bullet_X = 9'd60; bus.Bullet_Y = 9'd66; frame_tick(); hits += int'(p_bh);
    bus.Bullet_X = 9'd60; bus.Bullet_Y = 9'd36; frame_tick(); hits += int'(p_bh);
    bus.Bullet_X = 9'd46; bus.Bullet_Y = 9'd50; frame_tick(); hits += int'(p_bh);
    bus.Bullet_X = 9'd60; bus.Bullet_Y = 9'd50; bus.bullet_valid = 1'b0; frame_tick(); hits += int'(p_bh);
    n_cmp++; if (hits !== 0 || bus.hp !== 3'd3) begin n_bad++; $display("FAIL edge_nohit: got hits=%0d hp=%0d want 0/3", hits, bus.hp); end
    bus.Bullet_X = 9'd47; bus.Bullet_Y = 9'd40; bus.bullet_valid = 1'b1;
    frame_tick();
    n_cmp++; if (p_bh !== 1'b1 || bus.hp !== 3'd2) begin n_bad++; $display("FAIL edge_hit: got bh=%b hp=%0d want 1/2", p_bh, bus.hp); end
    do_reset();
    bus.Obj_X_Pos = 9'd505; bus.Bullet_X = 9'd509; bus.Bullet_Y = 9'd50; bus.bullet_valid = 1'b1;
    frame_tick();
    n_cmp++; if (p_bh !== 1'b1) begin n_bad++; $display("FAIL wrap_hit: got %b want 1", p_bh); end
    $display("test_edge_touch: touching edges ignored, overlap at x=47 and x=509 hit");
  endtask

  task automatic test_kill_respawn;
    int hits, early, quiet;
    do_reset();
    bus.Bullet_X = 9'd60; bus.Bullet_Y = 9'd50; bus.bullet_valid = 1'b1;
    hits = 0; early = 0;
    for (int t = 1; t <= 19; t++) begin
      if (t == 19) begin bus.Player_X = 9'd60; bus.Player_Y = 9'd50; end
      frame_tick();
      hits += int'(p_bh);
      if (t < 19) early += int'(p_kill) + int'(p_ph);
    end
    n_cmp++; if (hits !== 3 || early !== 0) begin n_bad++; $display("FAIL kill_seq: got hits=%0d early=%0d want 3/0", hits, early); end
    n_cmp++; if ({p_bh, p_kill, p_ph} !== 3'b111) begin n_bad++; $display("FAIL kill_pulses: got %b want 111", {p_bh, p_kill, p_ph}); end
    n_cmp++; if (bus.is_alive !== 1'b0 || bus.hp !== 3'd0 || bus.kill_count !== 8'd1) begin
      n_bad++; $display("FAIL dead_state: got alive=%b hp=%0d kills=%0d want 0/0/1", bus.is_alive, bus.hp, bus.kill_count); end
    quiet = 0;
    repeat (119) begin
      frame_tick();
      quiet += int'(p_bh) + int'(p_kill) + int'(p_resp) + int'(p_ph);
    end
    n_cmp++; if (quiet !== 0 || bus.is_alive !== 1'b0) begin
      n_bad++; $display("FAIL dead_quiet: got pulses=%0d alive=%b want 0/0", quiet, bus.is_alive); end
    frame_tick();
    n_cmp++; if (p_resp !== 1'b1 || bus.is_alive !== 1'b1 || bus.hp !== 3'd3) begin
      n_bad++; $display("FAIL respawn: got resp=%b alive=%b hp=%0d want 1/1/3", p_resp, bus.is_alive, bus.hp); end
    frame_tick();
    n_cmp++; if (p_bh !== 1'b1 || bus.hp !== 3'd2) begin n_bad++; $display("FAIL post_respawn_hit: got bh=%b hp=%0d want 1/2", p_bh, bus.hp); end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL kill_pulse_width: got %0d stray want 0", stray); end
    $display("test_kill_respawn: kills=%0d hp=%0d", bus.kill_count, bus.hp);
  endtask

  task automatic test_player_contact;
    int n_ph, on_time;
    do_reset();
    bus.Player_X = 9'd60; bus.Player_Y = 9'd50;
    n_ph = 0; on_time = 0;
    for (int t = 1; t <= 70; t++) begin
      frame_tick();
      if (p_ph) begin
        n_ph++;
        if (t == 1 || t == 32 || t == 63) on_time++;
      end
    end
    n_cmp++; if (n_ph !== 3 || on_time !== 3) begin n_bad++; $display("FAIL contact_sched: got n=%0d on_time=%0d want 3/3", n_ph, on_time); end
    n_cmp++; if (bus.hp !== 3'd3 || stray !== 0) begin n_bad++; $display("FAIL contact_side: got hp=%0d stray=%0d want 3/0", bus.hp, stray); end
    $display("test_player_contact: %0d player_hit pulses in 70 ticks", n_ph);
  endtask

  task automatic test_reset_mid_hurt;
    int cnt;
    do_reset();
    bus.Bullet_X = 9'd60; bus.Bullet_Y = 9'd50; bus.bullet_valid = 1'b1;
    frame_tick();
    n_cmp++; if (bus.is_hurt !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hurt: got %b want 1", bus.is_hurt); end
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.hp !== 3'd3 || bus.is_hurt !== 1'b0 || bus.is_alive !== 1'b1) begin
      n_bad++; $display("FAIL async_reset: got hp=%0d hurt=%b alive=%b want 3/0/1", bus.hp, bus.is_hurt, bus.is_alive); end
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge Clk);
      #1;
      cnt += int'(bus.bullet_hit) + int'(bus.kill) + int'(bus.respawn) + int'(bus.player_hit);
    end
    n_cmp++; if (cnt !== 0 || bus.hp !== 3'd3) begin n_bad++; $display("FAIL post_reset_quiet: got pulses=%0d hp=%0d want 0/3", cnt, bus.hp); end
    $display("test_reset_mid_hurt: hp=%0d hurt=%b after release", bus.hp, bus.is_hurt);
  endtask

  initial begin
    Reset_n = 1'b0;
    set_defaults();
    test_reset();
    test_hit_invuln();
    test_edge_touch();
    test_kill_respawn();
    test_player_contact();
    test_reset_mid_hurt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
